// File: rtl/uart_crc_frame_link.sv
// uart_crc_frame_link: framed 8N1 UART link, PAYLOAD_BYTES data bytes plus a CRC-8 trailer byte
//   Optional: define UART_CRC_LOOPBACK_EN to feed the RX path from txd instead of rxd.
//   clk, reset (async, active-high)
//   tx_data/tx_valid/tx_ready : payload in (byte 0 = [7:0], sent first), txd serial out
//   rxd                       : serial in
//   rx_data/rx_valid/rx_crc_ok: received payload, frame-complete pulse, CRC match flag
//   rx_frame_err              : pulse on bad stop bit or inter-byte timeout
module uart_crc_frame_link #(
    parameter int         PAYLOAD_BYTES   = 2,
    parameter int         CLKS_PER_BIT    = 16,
    parameter logic [7:0] CRC_POLY        = 8'h07,
    parameter logic [7:0] CRC_INIT        = 8'h00,
    parameter int         RX_TIMEOUT_BITS = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [8*PAYLOAD_BYTES-1:0] tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic                       txd,
    input  logic                       rxd,
    output logic [8*PAYLOAD_BYTES-1:0] rx_data,
    output logic                       rx_valid,
    output logic                       rx_crc_ok,
    output logic                       rx_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(PAYLOAD_BYTES + 1);
    localparam int TO = RX_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GW = $clog2(TO);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] CRC_IDX  = IW'(PAYLOAD_BYTES);
    localparam logic [GW-1:0] GAP_LAST = GW'(TO - 1);

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++)
            r = r[7] ? {r[6:0], 1'b0} ^ CRC_POLY : {r[6:0], 1'b0};
        return r;
    endfunction

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [IW-1:0] tx_idx;
    logic [8*PAYLOAD_BYTES-1:0] tx_buf;
    logic [7:0] tx_crc, tx_byte;
    logic tx_bit_end;

    // tx_idx == CRC_IDX selects the trailer; tx_crc is final by then
    always_comb begin
        tx_bit_end = tx_cnt == BIT_LAST;
        tx_byte = tx_idx == CRC_IDX ? tx_crc : tx_buf[8*int'(tx_idx) +: 8];
        tx_next = tx_state == TX_IDLE ? (tx_valid ? TX_START : TX_IDLE)
                : !tx_bit_end ? tx_state
                : tx_state == TX_START ? TX_DATA
                : tx_state == TX_DATA ? (tx_bit == 3'd7 ? TX_STOP : TX_DATA)
                : tx_idx == CRC_IDX ? TX_IDLE : TX_START;
        tx_ready = tx_state == TX_IDLE;
        txd = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_byte[tx_bit] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_idx <= '0;
            tx_buf <= '0;
            tx_crc <= CRC_INIT;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= '0;
                if (tx_valid) begin
                    tx_buf <= tx_data;
                    tx_crc <= CRC_INIT;
                    tx_idx <= '0;
                    tx_bit <= '0;
                end
            end else begin
                tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
                if (tx_bit_end && tx_state == TX_DATA)
                    tx_bit <= tx_bit + 1'b1;
                if (tx_bit_end && tx_state == TX_STOP) begin
                    tx_idx <= tx_idx + 1'b1;
                    if (tx_idx != CRC_IDX)
                        tx_crc <= crc8_step(tx_crc, tx_byte);
                end
            end
        end
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_GAP, RX_DONE} rx_state_t;
    rx_state_t rx_state, rx_next;
    logic rx_in, rx_s1, rx_s2, rx_prev, rx_fall, rx_mid, rx_err;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [IW-1:0] rx_idx;
    logic [GW-1:0] rx_gap;
    logic [7:0] rx_sh, rx_crc;
    logic [8*PAYLOAD_BYTES-1:0] rx_buf;

`ifdef UART_CRC_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = rxd;
    assign rx_in = txd;
`else
    assign rx_in = rxd;
`endif

    // Starts are edge-triggered, so a line held low after a bad stop cannot re-arm until it rises
    always_comb begin
        rx_fall = rx_prev & ~rx_s2;
        rx_mid = rx_state == RX_START ? rx_cnt == BIT_HALF : rx_cnt == BIT_LAST;
        rx_err = (rx_state == RX_STOP && rx_mid && !rx_s2) ||
                 (rx_state == RX_GAP && !rx_fall && rx_gap == GAP_LAST);
        rx_next = rx_state == RX_IDLE || rx_state == RX_GAP ? (rx_fall ? RX_START : rx_err ? RX_IDLE : rx_state)
                : rx_state == RX_DONE ? RX_IDLE
                : !rx_mid ? rx_state
                : rx_state == RX_START ? (rx_s2 ? RX_IDLE : RX_DATA)
                : rx_state == RX_DATA ? (rx_bit == 3'd7 ? RX_STOP : RX_DATA)
                : !rx_s2 ? RX_IDLE
                : rx_idx == CRC_IDX ? RX_DONE : RX_GAP;
        rx_valid = rx_state == RX_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            {rx_s1, rx_s2, rx_prev} <= 3'b111;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_idx <= '0;
            rx_gap <= '0;
            rx_sh <= '0;
            rx_crc <= CRC_INIT;
            rx_buf <= '0;
            rx_data <= '0;
            rx_crc_ok <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_state <= rx_next;
            {rx_s1, rx_s2, rx_prev} <= {rx_in, rx_s1, rx_s2};
            rx_frame_err <= rx_err;
            rx_cnt <= rx_next != rx_state || rx_mid ? '0 : rx_cnt + 1'b1;
            rx_gap <= rx_state == RX_GAP ? rx_gap + 1'b1 : '0;
            if ((rx_state == RX_IDLE || rx_state == RX_GAP) && rx_fall)
                rx_bit <= '0;
            if (rx_state == RX_IDLE && rx_fall) begin
                rx_idx <= '0;
                rx_crc <= CRC_INIT;
            end
            if (rx_state == RX_DATA && rx_mid) begin
                rx_sh <= {rx_s2, rx_sh[7:1]};
                rx_bit <= rx_bit + 1'b1;
            end
            // Result registers load with the CRC stop sample so they are valid alongside rx_valid
            if (rx_state == RX_STOP && rx_mid && rx_s2) begin
                if (rx_idx == CRC_IDX) begin
                    rx_data <= rx_buf;
                    rx_crc_ok <= rx_sh == rx_crc;
                end else begin
                    rx_buf[8*int'(rx_idx) +: 8] <= rx_sh;
                    rx_crc <= crc8_step(rx_crc, rx_sh);
                    rx_idx <= rx_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_crc_frame_link.sv
// tb_uart_crc_frame_link: randomized scoreboard bench for uart_crc_frame_link
module tb_uart_crc_frame_link;
    localparam int P = 2;
    localparam int W = 8 * P;
    localparam int CPB = 16;
    localparam logic [7:0] POLY = 8'h07;
    localparam logic [7:0] INIT = 8'h00;
    localparam int FRAME = (P + 1) * 10 * CPB;

    logic clk = 0, reset = 1, tx_valid = 0, rxd_drv = 1, loop = 0, tx_mon_en = 1;
    logic [W-1:0] tx_data = '0, rx_data, last_data = '0;
    logic tx_ready, txd, rxd, rx_valid, rx_crc_ok, rx_frame_err;
    int compared = 0, mismatched = 0;

    typedef struct {logic err; logic [W-1:0] data; logic ok;} ev_t;
    ev_t rx_q[$];
    logic [7:0] tx_q[$];

    assign rxd = loop ? txd : rxd_drv;

    uart_crc_frame_link #(.PAYLOAD_BYTES(P), .CLKS_PER_BIT(CPB), .CRC_POLY(POLY),
                          .CRC_INIT(INIT), .RX_TIMEOUT_BITS(20)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .txd(txd), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_crc_ok(rx_crc_ok),
        .rx_frame_err(rx_frame_err));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // CRC as polynomial long division over the message bit stream
    function automatic logic [7:0] ref_crc(input logic [W-1:0] d);
        logic [7:0] c;
        logic fb;
        c = INIT;
        for (int k = 0; k < P; k++)
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ d[8*k+j];
                c = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
            end
        return c;
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (!reset && (rx_valid || rx_frame_err)) begin
            if (rx_q.size() == 0)
                check("rx_unexpected_pulse", {rx_valid, rx_frame_err}, 2'b00);
            else begin
                e = rx_q.pop_front();
                check("rx_frame_err", rx_frame_err, e.err);
                check("rx_valid", rx_valid, !e.err);
                if (!e.err) begin
                    check("rx_data", rx_data, e.data);
                    check("rx_crc_ok", rx_crc_ok, e.ok);
                end
            end
        end
    end

    initial begin : tx_mon
        logic [7:0] b;
        logic en, start;
        forever begin
            @(negedge clk);
            if (!reset && txd === 1'b0) begin
                en = tx_mon_en;
                repeat (CPB / 2) @(negedge clk);
                start = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                if (en) begin
                    check("tx_start_bit", start, 1'b0);
                    check("tx_stop_bit", txd, 1'b1);
                    if (tx_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL tx_unexpected_byte: got %0h expected none", b);
                    end else
                        check("tx_byte", b, tx_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_frame(input logic [W-1:0] d, input logic with_rx);
        for (int k = 0; k < P; k++) tx_q.push_back(d[8*k +: 8]);
        tx_q.push_back(ref_crc(d));
        if (with_rx) begin
            rx_q.push_back('{1'b0, d, 1'b1});
            last_data = d;
        end
    endtask

    task automatic count_low(output int n);
        n = 1;
        while (!tx_ready && n < 2 * FRAME) begin
            @(negedge clk);
            if (!tx_ready) n++;
        end
    endtask

    task automatic send_tx(input logic [W-1:0] d);
        int n;
        tx_data = d;
        tx_valid = 1;
        n = 0;
        while (!tx_ready && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", tx_ready, 1'b1);
        @(negedge clk);
        tx_valid = 0;
        tx_data = W'($urandom);
        check("tx_start_immediate", {tx_ready, txd}, 2'b00);
        count_low(n);
        check("tx_frame_len", n, FRAME);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop, input int gap_bits);
        rxd_drv = 0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd_drv = stop;
        repeat (CPB) @(negedge clk);
        rxd_drv = 1;
        repeat (gap_bits * CPB) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [W-1:0] d, input logic [7:0] cx, input int gmax);
        rx_q.push_back('{1'b0, d, cx == 8'h00});
        last_data = d;
        for (int k = 0; k < P; k++) rx_byte(d[8*k +: 8], 1'b1, int'($urandom_range(gmax, 0)));
        rx_byte(ref_crc(d) ^ cx, 1'b1, 2);
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((rx_q.size() != 0 || tx_q.size() != 0) && t < 4 * FRAME) begin
            @(negedge clk);
            t++;
        end
        check(nm, rx_q.size() + tx_q.size(), 0);
        rx_q.delete();
        tx_q.delete();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] d, d2;
        logic [7:0] cx;
        int n, pulses;
        repeat (3) @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_tx_ready", tx_ready, 1'b1);
        check("reset_rx_data", rx_data, 0);
        check("reset_pulses", {rx_valid, rx_crc_ok, rx_frame_err}, 3'b000);
        reset = 0;
        repeat (4) @(negedge clk);

        loop = 1;
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h1B);
        rx_q.push_back('{1'b0, 16'h0201, 1'b1});
        last_data = 16'h0201;
        send_tx(16'h0201);
        drain("drain_fixed_loopback");
        for (int i = 0; i < 4; i++) begin
            d = W'($urandom);
            expect_frame(d, 1'b1);
            send_tx(d);
            drain("drain_random_loopback");
        end

        loop = 0;
        for (int i = 0; i < 4; i++) begin
            cx = 8'h00;
            if ($urandom_range(1, 0) == 1) cx = 8'h01 << $urandom_range(7, 0);
            rx_frame(W'($urandom), cx, 5);
            drain("drain_random_rx");
        end
        rx_q.push_back('{1'b0, 16'h0201, 1'b0});
        last_data = 16'h0201;
        for (int k = 0; k < P; k++) rx_byte(8'(k + 1), 1'b1, 0);
        rx_byte(8'h1C, 1'b1, 2);
        drain("drain_bad_crc");
        check("bad_crc_rx_data_held", rx_data, 16'h0201);

        rx_q.push_back('{1'b1, '0, 1'b0});
        rx_byte(8'($urandom), 1'b1, 0);
        rx_byte(8'($urandom), 1'b0, 3);
        drain("drain_bad_stop");
        check("bad_stop_rx_data_kept", rx_data, last_data);
        check("bad_stop_crc_ok_kept", rx_crc_ok, 1'b0);

        rx_q.push_back('{1'b1, '0, 1'b0});
        rx_byte(8'($urandom), 1'b1, 21);
        drain("drain_timeout");
        rx_frame(W'($urandom), 8'h00, 3);
        drain("drain_after_timeout");

        pulses = 0;
        rxd_drv = 0;
        repeat (CPB / 4) @(negedge clk);
        rxd_drv = 1;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (rx_valid || rx_frame_err) pulses++;
        end
        check("glitch_no_pulses", pulses, 0);

        loop = 1;
        d = W'($urandom);
        d2 = W'($urandom);
        expect_frame(d, 1'b1);
        expect_frame(d2, 1'b1);
        tx_data = d;
        tx_valid = 1;
        n = 0;
        while (!tx_ready && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tx_data = d2;
        count_low(n);
        check("b2b_frame1_len", n, FRAME);
        @(negedge clk);
        check("b2b_ready_one_cycle", {tx_ready, txd}, 2'b00);
        tx_valid = 0;
        tx_data = W'($urandom);
        count_low(n);
        check("b2b_frame2_len", n, FRAME);
        drain("drain_back_to_back");

        loop = 0;
        tx_mon_en = 0;
        tx_data = W'($urandom);
        tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
        repeat (15 * CPB) @(negedge clk);
        #2 reset = 1;
        #1;
        check("async_reset_txd", txd, 1'b1);
        check("async_reset_tx_ready", tx_ready, 1'b1);
        check("async_reset_rx_data", rx_data, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (12 * CPB) @(negedge clk);
        tx_q.delete();
        tx_mon_en = 1;
        loop = 1;
        d = W'($urandom);
        expect_frame(d, 1'b1);
        send_tx(d);
        drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
